// File: rtl/seq_sort4_stream_if.sv
// Valid/ready bus for the streaming sorter: a load channel in and a sorted-word channel out.
interface seq_sort4_stream_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/seq_sort4_stream.sv
// Streaming block sorter: load N words, bubble-sort in place one compare-exchange per clock, stream out.
// Optional macro SEQ_SORT4_STREAM_DESCEND_EN selects largest-first output order.
module seq_sort4_stream #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic                clk,
    input  logic                rst,
    seq_sort4_stream_if.slave   bus,
    output logic                busy_o
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]    i_q, i_d;
    logic [CW-1:0]    j_q, j_d;
    logic [WIDTH-1:0] data_q [N];
    logic [WIDTH-1:0] data_d [N];
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    j_nxt;
    logic             do_swap;

    assign bus.in_ready  = (state_q == LOAD) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy_o        = (state_q != LOAD);
    assign j_nxt         = j_q + CW'(1);

    // Equal words never swap, so the sort is stable in both orders.
`ifdef SEQ_SORT4_STREAM_DESCEND_EN
    assign do_swap = data_q[j_q] < data_q[j_nxt];
`else
    assign do_swap = data_q[j_q] > data_q[j_nxt];
`endif

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        i_d         = i_q;
        j_d         = j_q;
        data_d      = data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            LOAD: begin
                if (bus.in_valid) begin
                    data_d[wr_cnt_q] = bus.in_data;
                    if (wr_cnt_q == CW'(N - 1)) begin
                        wr_cnt_d = '0;
                        i_d      = '0;
                        j_d      = '0;
                        state_d  = SORT;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CW'(1);
                    end
                end
            end
            SORT: begin
                if (do_swap) begin
                    data_d[j_q]   = data_q[j_nxt];
                    data_d[j_nxt] = data_q[j_q];
                end
                if (j_q == CW'(N - 2) - i_q) begin
                    j_d = '0;
                    if (i_q == CW'(N - 2)) begin
                        // The last compare settles word 0, so it is preloaded for the first OUT cycle.
                        i_d         = '0;
                        rd_cnt_d    = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = data_d[0];
                        state_d     = OUT;
                    end else begin
                        i_d = i_q + CW'(1);
                    end
                end else begin
                    j_d = j_nxt;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    if (rd_cnt_q == CW'(N - 1)) begin
                        rd_cnt_d    = '0;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        state_d     = LOAD;
                    end else begin
                        rd_cnt_d   = rd_cnt_q + CW'(1);
                        out_data_d = data_q[rd_cnt_d];
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            i_q         <= '0;
            j_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            i_q         <= i_d;
            j_q         <= j_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end
endmodule

// File: tb/tb_seq_sort4_stream.sv
// Scoreboard bench for seq_sort4_stream: a sorted copy of each loaded block is queued and
// compared word by word as the DUT streams it out.
module tb_seq_sort4_stream;
    typedef logic [7:0] blk_t [4];

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [7:0] expQ [$];
    int         nVec = 0;
    int         nErr = 0;

    seq_sort4_stream_if #(.WIDTH(8)) bus ();

    seq_sort4_stream #(.WIDTH(8), .N(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    function automatic blk_t sortModel(input blk_t b);
        blk_t       r;
        logic [7:0] key;
        int         k;
        r = b;
        for (int a = 1; a < 4; a++) begin
            key = r[a];
            k = a - 1;
`ifdef SEQ_SORT4_STREAM_DESCEND_EN
            while (k >= 0 && r[k] < key) begin
`else
            while (k >= 0 && r[k] > key) begin
`endif
                r[k + 1] = r[k];
                k--;
            end
            r[k + 1] = key;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pop and compare on every output transfer; sampled mid-cycle, ahead of the edge that takes it.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            nVec++;
            if (expQ.size() == 0) begin
                nErr++;
                $display("[TB] FAIL outWord: got %h while no word was expected", bus.out_data);
            end else begin
                logic [7:0] e;
                e = expQ.pop_front();
                if (bus.out_data !== e) begin
                    nErr++;
                    $display("[TB] FAIL outWord: got %h, expected %h", bus.out_data, e);
                end
            end
        end
    end

    task automatic loadBlock(input blk_t b, input bit gappy);
        blk_t s;
        int   t;
        for (int k = 0; k < 4; k++) begin
            if (gappy && k > 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'hEE;
                step();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = b[k];
            t = 0;
            while (bus.in_ready !== 1'b1 && t < 50) begin
                step();
                t++;
            end
            if (t >= 50) begin
                nVec++;
                nErr++;
                $display("[TB] FAIL loadTimeout: in_ready=%b, expected 1", bus.in_ready);
            end
            step();
        end
        bus.in_valid = 1'b0;
        s = sortModel(b);
        for (int k = 0; k < 4; k++) expQ.push_back(s[k]);
    endtask

    // Starts in the cycle after the last input transfer, which counts as cycle 1.
    task automatic waitFirstOut(output int lat);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic waitDrain(output bit ok);
        int t;
        t = 0;
        while ((expQ.size() != 0 || bus.out_valid === 1'b1) && t < 100) begin
            step();
            t++;
        end
        ok = (t < 100);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        step();
        step();
        nVec++;
        if (bus.in_ready !== 1'b0) begin nErr++; $display("[TB] FAIL resetInReady: got %b, expected 0", bus.in_ready); end
        nVec++;
        if (bus.out_valid !== 1'b0) begin nErr++; $display("[TB] FAIL resetOutValid: got %b, expected 0", bus.out_valid); end
        nVec++;
        if (bus.out_data !== 8'h00) begin nErr++; $display("[TB] FAIL resetOutData: got %h, expected 00", bus.out_data); end
        nVec++;
        if (busy !== 1'b0) begin nErr++; $display("[TB] FAIL resetBusy: got %b, expected 0", busy); end
        rst = 1'b0;
        #1;
        nVec++;
        if (bus.in_ready !== 1'b1) begin nErr++; $display("[TB] FAIL releaseInReady: got %b, expected 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        blk_t       b;
        int         lat;
        bit         ok;
        logic [7:0] first;
        b = '{8'h30, 8'h10, 8'h40, 8'h20};
`ifdef SEQ_SORT4_STREAM_DESCEND_EN
        first = 8'h40;
`else
        first = 8'h10;
`endif
        loadBlock(b, 1'b0);
        nVec++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin nErr++; $display("[TB] FAIL sortBusy: busy=%b in_ready=%b, expected 1/0", busy, bus.in_ready); end
        waitFirstOut(lat);
        nVec++;
        if (lat != 7) begin nErr++; $display("[TB] FAIL latency: got %0d cycles, expected 7", lat); end
        nVec++;
        if (bus.out_data !== first) begin nErr++; $display("[TB] FAIL firstWord: got %h, expected %h", bus.out_data, first); end
        step();
        step();
        step();
        nVec++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin nErr++; $display("[TB] FAIL lastWordCycle: in_ready=%b out_valid=%b, expected 0/1", bus.in_ready, bus.out_valid); end
        step();
        nVec++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            nErr++;
            $display("[TB] FAIL afterDrain: in_ready=%b busy=%b out_valid=%b, expected 1/0/0", bus.in_ready, busy, bus.out_valid);
        end
        waitDrain(ok);
        nVec++;
        if (!ok || expQ.size() != 0) begin nErr++; $display("[TB] FAIL basicDrain: %0d words left, expected 0", expQ.size()); end
    endtask

    task automatic test_sorted_reversed();
        blk_t blks [2];
        int   lat;
        bit   ok;
        blks[0] = '{8'h01, 8'h02, 8'h03, 8'h04};
        blks[1] = '{8'hFF, 8'h80, 8'h7F, 8'h00};
        for (int n = 0; n < 2; n++) begin
            loadBlock(blks[n], 1'b0);
            waitFirstOut(lat);
            nVec++;
            if (lat != 7) begin nErr++; $display("[TB] FAIL sortLength%0d: got %0d cycles, expected 7", n, lat); end
            waitDrain(ok);
            nVec++;
            if (!ok) begin nErr++; $display("[TB] FAIL drain%0d: %0d words left, expected 0", n, expQ.size()); end
        end
    endtask

    task automatic test_duplicates();
        blk_t b;
        bit   ok;
        b = '{8'h55, 8'hAA, 8'h55, 8'h00};
        loadBlock(b, 1'b1);
        waitDrain(ok);
        nVec++;
        if (!ok) begin nErr++; $display("[TB] FAIL dupDrain: %0d words left, expected 0", expQ.size()); end
    endtask

    task automatic test_backpressure();
        blk_t       b;
        int         lat;
        bit         ok;
        logic [7:0] second;
        b = '{8'h30, 8'h10, 8'h40, 8'h20};
`ifdef SEQ_SORT4_STREAM_DESCEND_EN
        second = 8'h30;
`else
        second = 8'h20;
`endif
        loadBlock(b, 1'b0);
        waitFirstOut(lat);
        step();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            nVec++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== second) begin
                nErr++;
                $display("[TB] FAIL stall%0d: out_valid=%b out_data=%h, expected 1/%h", c, bus.out_valid, bus.out_data, second);
            end
            step();
        end
        bus.out_ready = 1'b1;
        waitDrain(ok);
        nVec++;
        if (!ok) begin nErr++; $display("[TB] FAIL stallDrain: %0d words left, expected 0", expQ.size()); end
    endtask

    task automatic test_ignore_during_sort();
        blk_t b;
        bit   ok;
        b = '{8'h21, 8'h05, 8'h13, 8'h07};
        loadBlock(b, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        for (int c = 0; c < 6; c++) begin
            nVec++;
            if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
                nErr++;
                $display("[TB] FAIL sortIgnore%0d: in_ready=%b busy=%b, expected 0/1", c, bus.in_ready, busy);
            end
            step();
        end
        bus.in_valid = 1'b0;
        waitDrain(ok);
        nVec++;
        if (!ok) begin nErr++; $display("[TB] FAIL ignoreDrain: %0d words left, expected 0", expQ.size()); end
    endtask

    task automatic test_reset_mid(input bit duringOut);
        blk_t b;
        int   lat;
        int   t;
        bit   ok;
        bit   stray;
        b = '{8'h30, 8'h10, 8'h40, 8'h20};
        loadBlock(b, 1'b0);
        if (duringOut) begin
            waitFirstOut(lat);
            t = 0;
            while (expQ.size() > 2 && t < 50) begin
                step();
                t++;
            end
        end else begin
            step();
            step();
        end
        rst = 1'b1;
        expQ.delete();
        step();
        rst = 1'b0;
        #1;
        nVec++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            nErr++;
            $display("[TB] FAIL midReset%0d: out_valid=%b busy=%b in_ready=%b, expected 0/0/1", duringOut, bus.out_valid, busy, bus.in_ready);
        end
        stray = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
            step();
        end
        nVec++;
        if (stray) begin nErr++; $display("[TB] FAIL staleBlock%0d: out_valid or busy rose, expected both 0", duringOut); end
        b = '{8'h09, 8'h03, 8'h07, 8'h01};
        loadBlock(b, 1'b0);
        waitDrain(ok);
        nVec++;
        if (!ok) begin nErr++; $display("[TB] FAIL postResetDrain%0d: %0d words left, expected 0", duringOut, expQ.size()); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_sorted_reversed();
        test_duplicates();
        test_backpressure();
        test_ignore_during_sort();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
